// File: rtl/presence_detector.sv
// Presence detector: synchronises a raw presence input, debounces its rise,
// stretches its fall with a hold timer and flags a stuck-active sensor.
module presence_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 100,
  parameter int unsigned STUCK_CYCLES    = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_sensor,
  input  logic enable,
  input  logic fault_clr,
  output logic sensor,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic fault
);

  localparam int unsigned CNT_MAX   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned SCNT_MAX  = (STUCK_CYCLES == 0) ? 1 : STUCK_CYCLES;
  localparam int unsigned SCNT_W    = $clog2(SCNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_PRESENT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_s1;
  logic              r_s2;
  logic [CNT_W-1:0]  r_cnt;
  logic [SCNT_W-1:0] r_scnt;
  logic              r_sensor;
  logic              r_rise;
  logic              r_fall;
  logic              r_fault;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic [SCNT_W-1:0] w_scnt_inc;
  logic              w_deb_done;
  logic              w_hold_done;
  logic              w_stuck_hit;

  // Saturating increments and terminal-count decodes
  assign w_cnt_inc   = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_scnt_inc  = (r_scnt == SCNT_W'(SCNT_MAX)) ? r_scnt : r_scnt + SCNT_W'(1);
  assign w_deb_done  = (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES));
  assign w_hold_done = (w_cnt_inc == CNT_W'(HOLD_CYCLES));
  assign w_stuck_hit = (STUCK_CYCLES != 0) && (w_scnt_inc == SCNT_W'(STUCK_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= '0;
      r_scnt   <= '0;
      r_sensor <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_s1   <= raw_sensor;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // Clear is placed before the FSM so a same-cycle FAULT entry overrides it
      if (fault_clr && (r_state != ST_FAULT)) begin
        r_fault <= 1'b0;
      end
      if (!enable) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_scnt   <= '0;
        r_sensor <= 1'b0;
        r_fall   <= r_sensor;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_s2) begin
              if (DEBOUNCE_CYCLES == 1) begin
                r_state  <= ST_PRESENT;
                r_cnt    <= '0;
                r_scnt   <= '0;
                r_sensor <= 1'b1;
                r_rise   <= 1'b1;
              end else begin
                r_state <= ST_CONFIRM;
                r_cnt   <= CNT_W'(1);
              end
            end
          end
          ST_CONFIRM: begin
            if (r_s2) begin
              if (w_deb_done) begin
                r_state  <= ST_PRESENT;
                r_cnt    <= '0;
                r_scnt   <= '0;
                r_sensor <= 1'b1;
                r_rise   <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
          ST_PRESENT: begin
            if (r_s2) begin
              r_scnt <= w_scnt_inc;
              if (w_stuck_hit) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end
            end else begin
              r_scnt <= '0;
              if (HOLD_CYCLES == 1) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_sensor <= 1'b0;
                r_fall   <= 1'b1;
              end else begin
                r_state <= ST_HOLD;
                r_cnt   <= CNT_W'(1);
              end
            end
          end
          ST_HOLD: begin
            if (!r_s2) begin
              if (w_hold_done) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_sensor <= 1'b0;
                r_fall   <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ST_PRESENT;
              r_cnt   <= '0;
              r_scnt  <= '0;
            end
          end
          ST_FAULT: begin
            // Fail-safe: sensor stays high until the input actually drops
            if (!r_s2) begin
              r_state <= ST_HOLD;
              r_cnt   <= CNT_W'(1);
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_scnt   <= '0;
            r_sensor <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sensor     = r_sensor;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign fault      = r_fault;

endmodule

// File: tb/tb_presence_detector.sv
// Self-checking bench for presence_detector: phase table with hand-derived
// expectations, a mid-HOLD reset sequence and random stimulus against a model.
module tb_presence_detector;

  localparam int unsigned D = 4;
  localparam int unsigned H = 8;
  localparam int unsigned S = 20;

  logic clk = 1'b0;
  logic reset;
  logic raw_sensor;
  logic enable;
  logic fault_clr;
  logic sensor;
  logic rise_pulse;
  logic fall_pulse;
  logic fault;

  int checks = 0;
  int errors = 0;

  // Reference model state: run lengths of the twice-delayed input
  logic m_s1, m_s2, m_sensor, m_rise, m_fall, m_fault, m_infault;
  int   hi_run, lo_run, stuck_run;

  typedef struct {
    logic raw;
    logic en;
    logic clr;
    int   n;
    logic e_sensor;
    logic e_fault;
    int   e_rise;
    int   e_fall;
  } vec_t;

  vec_t tbl[$];

  presence_detector #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_sensor(raw_sensor),
    .enable    (enable),
    .fault_clr (fault_clr),
    .sensor    (sensor),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_sensor = 0; m_rise = 0; m_fall = 0;
    m_fault = 0; m_infault = 0; hi_run = 0; lo_run = 0; stuck_run = 0;
  endtask

  task automatic model_edge();
    logic s2, prev, prev_f, set_f;
    s2 = m_s2; prev = m_sensor; prev_f = m_infault; set_f = 0;
    m_s2 = m_s1;
    m_s1 = raw_sensor;
    if (!enable) begin
      m_sensor = 0; m_infault = 0; hi_run = 0; lo_run = 0; stuck_run = 0;
    end else if (!m_sensor) begin
      if (s2) begin
        hi_run++;
        if (hi_run >= D) begin m_sensor = 1; hi_run = 0; stuck_run = 0; end
      end else hi_run = 0;
    end else if (s2) begin
      if (lo_run > 0) begin lo_run = 0; stuck_run = 0; end
      else if (!m_infault) begin
        stuck_run++;
        if (stuck_run == S) begin m_infault = 1; set_f = 1; end
      end
    end else begin
      lo_run++; stuck_run = 0; m_infault = 0;
      if (lo_run >= H) begin m_sensor = 0; lo_run = 0; end
    end
    m_rise = m_sensor && !prev;
    m_fall = !m_sensor && prev;
    if (set_f) m_fault = 1;
    else if (fault_clr && !prev_f) m_fault = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sensor", sensor, m_sensor);
    chk("model_rise", rise_pulse, m_rise);
    chk("model_fall", fall_pulse, m_fall);
    chk("model_fault", fault, m_fault);
  endtask

  function automatic vec_t mk(input logic raw, input logic en, input logic clr, input int n,
                              input logic es, input logic ef, input int er, input int efl);
    vec_t v;
    v.raw = raw; v.en = en; v.clr = clr; v.n = n;
    v.e_sensor = es; v.e_fault = ef; v.e_rise = er; v.e_fall = efl;
    return v;
  endfunction

  initial begin
    int rc, fc, run;
    reset = 0; raw_sensor = 0; enable = 1; fault_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sensor", sensor, 1'b0);
    chk("reset_rise", rise_pulse, 1'b0);
    chk("reset_fall", fall_pulse, 1'b0);
    chk("reset_fault", fault, 1'b0);
    reset = 1;

    // raw, en, clr, cycles, sensor, fault, #rise, #fall at the end of each phase
    tbl.push_back(mk(1, 1, 0,  6, 1, 0, 1, 0));  // rise after edge D+2
    tbl.push_back(mk(1, 1, 0,  2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0,  5, 1, 0, 0, 0));  // short drop is absorbed by hold
    tbl.push_back(mk(1, 1, 0,  6, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 10, 0, 0, 0, 1));  // fall after edge H+2
    tbl.push_back(mk(0, 1, 0,  2, 0, 0, 0, 0));
    for (int g = 0; g < 3; g++) begin             // 1-cycle glitches every 3 cycles
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0));
    end
    tbl.push_back(mk(1, 1, 0, 25, 1, 0, 1, 0));  // stuck: fault on edge D+2+S
    tbl.push_back(mk(1, 1, 0,  1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 14, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 10, 0, 1, 0, 1));  // leaves FAULT via HOLD, fault sticks
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  6, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0, 1));  // enable drop forces fall
    tbl.push_back(mk(1, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  3, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 20, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1, 1, 1, 0, 0));  // clear ignored inside FAULT
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0,  3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0,  2, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      raw_sensor = tbl[i].raw; enable = tbl[i].en; fault_clr = tbl[i].clr;
      rc = 0; fc = 0;
      repeat (tbl[i].n) begin
        tick();
        rc += int'(rise_pulse);
        fc += int'(fall_pulse);
      end
      chk($sformatf("vec%0d_sensor", i), sensor, tbl[i].e_sensor);
      chk($sformatf("vec%0d_fault", i), fault, tbl[i].e_fault);
      chk_int($sformatf("vec%0d_rises", i), rc, tbl[i].e_rise);
      chk_int($sformatf("vec%0d_falls", i), fc, tbl[i].e_fall);
    end
    fault_clr = 0; enable = 1;

    // Asynchronous reset while in HOLD
    raw_sensor = 1;
    repeat (6) tick();
    raw_sensor = 0;
    repeat (4) tick();
    chk("hold_sensor_before_reset", sensor, 1'b1);
    #3 reset = 0;
    #1;
    chk("async_rst_sensor", sensor, 1'b0);
    chk("async_rst_rise", rise_pulse, 1'b0);
    chk("async_rst_fall", fall_pulse, 1'b0);
    chk("async_rst_fault", fault, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    chk("in_rst_sensor", sensor, 1'b0);
    chk("in_rst_fall", fall_pulse, 1'b0);
    reset = 1;
    repeat (5) tick();

    // Random run-length stimulus against the model
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        raw_sensor = ~raw_sensor;
        run = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40))
                                          : int'($urandom_range(1, 14));
      end
      run--;
      enable    = ($urandom_range(0, 99) != 0);
      fault_clr = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
